// File: rtl/neural_stream_pkg.sv
// Shared types and parameter helpers for the neural sample stream packer.
// Holds the packer state encoding and the lane-ratio arithmetic.
package neural_stream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PACK     = 2'd2,
        DISCARD  = 2'd3
    } state_t;

    // Number of sample words per host word.
    function automatic int calc_ratio(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    // Lane index width; a single-lane packer still needs a 1-bit index.
    function automatic int calc_lane_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/neural_stream_packer_if.sv
// Sample-input, host-read and status signals of the neural stream packer.
// Handshakes: in_wen qualifies in_data/in_sof for one cycle (no backpressure); rd_en pops the head only while rd_empty=0.
interface neural_stream_packer_if
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 512,
    parameter int CNT_WIDTH = 16
);
    import neural_stream_pkg::*;

    logic                         rd_open;
    logic [IN_WIDTH-1:0]          in_data;
    logic                         in_wen;
    logic                         in_sof;
    logic                         rd_en;
    logic [OUT_WIDTH-1:0]         rd_data;
    logic                         rd_empty;
    logic                         overflow;
    logic                         overflow_clr;
    logic [$clog2(DEPTH+1)-1:0]   fill_level;
    logic [CNT_WIDTH-1:0]         dropped_frames;
    state_t                       state;

    modport slave (
        input  rd_open, in_data, in_wen, in_sof, rd_en, overflow_clr,
        output rd_data, rd_empty, overflow, fill_level, dropped_frames, state
    );

    modport master (
        output rd_open, in_data, in_wen, in_sof, rd_en, overflow_clr,
        input  rd_data, rd_empty, overflow, fill_level, dropped_frames, state
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// The head register holds its last value once the FIFO drains.
module sync_fifo_fwft
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;
    assign count_o = count_q;

    // A full FIFO still accepts a push when the same cycle pops a word.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign rd_next = rd_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_next;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // Next head: the word behind the popped one, or the incoming word when that is all there is.
            if (do_pop) begin
                if (count_q == CW'(1)) begin
                    if (do_push) head_d = push_data_i;
                end else begin
                    head_d = mem_q[rd_next];
                end
            end else if (empty_o && do_push) begin
                head_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/neural_stream_packer.sv
// Packs IN_WIDTH sample words into OUT_WIDTH host words and queues them in a FWFT FIFO.
// After an overflow the stream resumes only at the next start-of-frame word.
module neural_stream_packer
    import neural_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 512,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  bus_clk,
    input  logic                  reset_n,
    neural_stream_packer_if.slave ifc
);
    localparam int R      = calc_ratio(OUT_WIDTH, IN_WIDTH);
    localparam int LANE_W = calc_lane_width(R);
    localparam int CW     = $clog2(DEPTH+1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R-1);

    state_t                 state_q, state_d;
    logic [LANE_W-1:0]      lane_q, lane_d, take_lane;
    logic [OUT_WIDTH-1:0]   pack_q, pack_d;
    logic [OUT_WIDTH-1:0]   push_data_q, push_data_d;
    logic                   push_q, push_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]   dropped_q, dropped_d;
    logic                   flush, reject, take;
    logic [OUT_WIDTH-1:0]   fifo_head;
    logic                   fifo_empty, fifo_full;
    logic [CW-1:0]          fifo_count;

    assign flush  = !ifc.rd_open || (state_q == IDLE);
    // Mirrors the FIFO acceptance rule: full and not popping means the registered group is lost.
    assign reject = push_q && !flush && fifo_full && !(ifc.rd_en && !fifo_empty);

    sync_fifo_fwft #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (bus_clk),
        .rst_ni      (reset_n),
        .flush_i     (flush),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (ifc.rd_en),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        overflow_d  = overflow_q;
        dropped_d   = dropped_q;
        take        = 1'b0;
        take_lane   = '0;
        if (!ifc.rd_open) begin
            state_d = IDLE;
            lane_d  = '0;
            pack_d  = '0;
        end else begin
            unique case (state_q)
                IDLE:              state_d = WAIT_SOF;
                WAIT_SOF, DISCARD: take = ifc.in_wen && ifc.in_sof;
                PACK: begin
                    if (reject) begin
                        state_d = DISCARD;
                        lane_d  = '0;
                        take    = ifc.in_wen && ifc.in_sof;
                    end else begin
                        take      = ifc.in_wen;
                        take_lane = ifc.in_sof ? '0 : lane_q;
                    end
                end
                default:           state_d = IDLE;
            endcase
            // A start-of-frame word always restarts the group at lane 0, dropping any partial group.
            if (take) begin
                state_d = PACK;
                pack_d[int'(take_lane)*IN_WIDTH +: IN_WIDTH] = ifc.in_data;
                if (take_lane == LAST_LANE) begin
                    push_d      = 1'b1;
                    push_data_d = pack_d;
                    lane_d      = '0;
                end else begin
                    lane_d = take_lane + 1'b1;
                end
            end
        end
        if (reject) begin
            overflow_d = 1'b1;
            if (dropped_q != '1) dropped_d = dropped_q + 1'b1;
        end else if (ifc.overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            pack_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            overflow_q  <= overflow_d;
            dropped_q   <= dropped_d;
        end
    end

    assign ifc.rd_data        = fifo_head;
    assign ifc.rd_empty       = fifo_empty;
    assign ifc.fill_level     = fifo_count;
    assign ifc.overflow       = overflow_q;
    assign ifc.dropped_frames = dropped_q;
    assign ifc.state          = state_q;

endmodule

// File: tb/tb_neural_stream_packer.sv
// Directed and randomized bench for neural_stream_packer with R=2, DEPTH=4.
// Expected host words come from a frame-level packing model and constants.
module tb_neural_stream_packer;
  import neural_stream_pkg::*;

  localparam int IW    = 16;
  localparam int OW    = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;
  localparam int R     = OW / IW;

  logic bus_clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [OW-1:0] exp_q[$];
  logic [IW-1:0] part_q[$];
  bit started;

  neural_stream_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) ifc();

  neural_stream_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .bus_clk (bus_clk),
    .reset_n (reset_n),
    .ifc     (ifc)
  );

  // clock / watchdog
  always #5 bus_clk = ~bus_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [IW-1:0] d, input logic s);
    ifc.in_data = d;
    ifc.in_wen  = 1'b1;
    ifc.in_sof  = s;
    tick();
    ifc.in_wen  = 1'b0;
    ifc.in_sof  = 1'b0;
  endtask

  task automatic pop_val(input string tag, input logic [OW-1:0] e);
    check({tag, "_nonempty"}, 64'(ifc.rd_empty), 64'd0);
    check(tag, 64'(ifc.rd_data), 64'(e));
    ifc.rd_en = 1'b1;
    tick();
    ifc.rd_en = 1'b0;
  endtask

  // reference model: frame-level packing of accepted words
  task automatic model_word(input logic [IW-1:0] d, input logic s);
    logic [OW-1:0] w;
    if (s) begin
      part_q.delete();
      started = 1'b1;
    end
    if (!started) return;
    part_q.push_back(d);
    if (part_q.size() == R) begin
      w = '0;
      for (int i = 0; i < R; i++) w[i*IW +: IW] = part_q[i];
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  initial begin
    logic [IW-1:0] d;
    logic          s;
    logic [OW-1:0] e;

    ifc.rd_open = 1'b0;
    ifc.in_data = '0;
    ifc.in_wen  = 1'b0;
    ifc.in_sof  = 1'b0;
    ifc.rd_en   = 1'b0;
    ifc.overflow_clr = 1'b0;
    started = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_rd_data",  64'(ifc.rd_data), 64'd0);
    check("rst_rd_empty", 64'(ifc.rd_empty), 64'd1);
    check("rst_overflow", 64'(ifc.overflow), 64'd0);
    check("rst_fill",     64'(ifc.fill_level), 64'd0);
    check("rst_dropped",  64'(ifc.dropped_frames), 64'd0);
    check("rst_state",    64'(ifc.state), 64'(IDLE));
    reset_n = 1'b1;
    tick();

    // basic packing, 2-cycle latency, read side
    ifc.rd_open = 1'b1;
    tick();
    check("t1_wait_sof", 64'(ifc.state), 64'(WAIT_SOF));
    send(16'h0999, 1'b0);
    send(16'h1111, 1'b1);
    check("t1_pack", 64'(ifc.state), 64'(PACK));
    send(16'h2222, 1'b0);
    check("t1_latency_not_yet", 64'(ifc.rd_empty), 64'd1);
    send(16'h3333, 1'b0);
    check("t1_latency_2cyc", 64'(ifc.rd_empty), 64'd0);
    check("t1_head0", 64'(ifc.rd_data), 64'h22221111);
    send(16'h4444, 1'b0);
    tick();
    check("t1_fill2", 64'(ifc.fill_level), 64'd2);
    check("t1_no_ovf", 64'(ifc.overflow), 64'd0);
    pop_val("t1_w0", 32'h22221111);
    pop_val("t1_w1", 32'h44443333);
    check("t1_empty", 64'(ifc.rd_empty), 64'd1);
    check("t1_hold", 64'(ifc.rd_data), 64'h44443333);
    ifc.rd_en = 1'b1;
    tick();
    ifc.rd_en = 1'b0;
    check("t1_underflow_fill", 64'(ifc.fill_level), 64'd0);
    check("t1_underflow_empty", 64'(ifc.rd_empty), 64'd1);
    check("t1_underflow_hold", 64'(ifc.rd_data), 64'h44443333);

    // misaligned frame restart
    send(16'hAAAA, 1'b1);
    send(16'hBBBB, 1'b1);
    send(16'hCCCC, 1'b0);
    tick();
    check("t2_fill1", 64'(ifc.fill_level), 64'd1);
    pop_val("t2_word", 32'hCCCCBBBB);
    check("t2_empty", 64'(ifc.rd_empty), 64'd1);

    // overflow, discard until sof, clear loses to set
    for (int i = 0; i < 8; i++) send(IW'(16'hA000 + i), (i == 0));
    send(16'hB000, 1'b0);
    send(16'hB001, 1'b0);
    ifc.overflow_clr = 1'b1;
    send(16'h7777, 1'b0);
    ifc.overflow_clr = 1'b0;
    check("t3_ovf_set_wins", 64'(ifc.overflow), 64'd1);
    check("t3_dropped1", 64'(ifc.dropped_frames), 64'd1);
    check("t3_fill4", 64'(ifc.fill_level), 64'd4);
    check("t3_discard", 64'(ifc.state), 64'(DISCARD));
    send(16'h8888, 1'b0);
    check("t3_still_discard", 64'(ifc.state), 64'(DISCARD));
    pop_val("t3_w0", 32'hA001A000);
    send(16'h5555, 1'b1);
    send(16'h6666, 1'b0);
    tick();
    check("t3_refill4", 64'(ifc.fill_level), 64'd4);
    check("t3_dropped_still1", 64'(ifc.dropped_frames), 64'd1);
    pop_val("t3_w1", 32'hA003A002);
    pop_val("t3_w2", 32'hA005A004);
    pop_val("t3_w3", 32'hA007A006);
    pop_val("t3_resume", 32'h66665555);
    check("t3_empty", 64'(ifc.rd_empty), 64'd1);

    // push and pop on a full FIFO in the same cycle
    for (int i = 0; i < 8; i++) send(IW'(16'hC000 + i), (i == 0));
    tick();
    check("t4_full", 64'(ifc.fill_level), 64'd4);
    send(16'hD000, 1'b0);
    send(16'hD001, 1'b0);
    pop_val("t4_pop_at_push", 32'hC001C000);
    check("t4_fill_kept", 64'(ifc.fill_level), 64'd4);
    check("t4_no_new_drop", 64'(ifc.dropped_frames), 64'd1);
    pop_val("t4_w1", 32'hC003C002);
    pop_val("t4_w2", 32'hC005C004);
    pop_val("t4_w3", 32'hC007C006);
    pop_val("t4_w4", 32'hD001D000);

    // close mid-group flushes, status retained, reopen waits for sof
    for (int i = 0; i < 6; i++) send(IW'(16'hE000 + i), (i == 0));
    send(16'hE100, 1'b0);
    tick();
    check("t5_fill3", 64'(ifc.fill_level), 64'd3);
    ifc.rd_open = 1'b0;
    tick();
    check("t5_flush_empty", 64'(ifc.rd_empty), 64'd1);
    check("t5_flush_fill", 64'(ifc.fill_level), 64'd0);
    check("t5_ovf_kept", 64'(ifc.overflow), 64'd1);
    check("t5_drop_kept", 64'(ifc.dropped_frames), 64'd1);
    check("t5_idle", 64'(ifc.state), 64'(IDLE));
    ifc.rd_open = 1'b1;
    tick();
    check("t5_reopen", 64'(ifc.state), 64'(WAIT_SOF));
    send(16'h9999, 1'b0);
    send(16'h9998, 1'b0);
    send(16'h1234, 1'b1);
    send(16'h5678, 1'b0);
    tick();
    check("t5_fill1", 64'(ifc.fill_level), 64'd1);
    pop_val("t5_word", 32'h56781234);

    ifc.overflow_clr = 1'b1;
    tick();
    ifc.overflow_clr = 1'b0;
    check("t6_ovf_cleared", 64'(ifc.overflow), 64'd0);
    check("t6_drop_kept", 64'(ifc.dropped_frames), 64'd1);

    // randomized traffic against the packing model, throttled below overflow
    ifc.rd_open = 1'b0;
    tick();
    ifc.rd_open = 1'b1;
    tick();
    exp_q.delete();
    part_q.delete();
    started = 1'b0;
    for (int c = 0; c < 600; c++) begin
      ifc.rd_en  = 1'b0;
      ifc.in_wen = 1'b0;
      ifc.in_sof = 1'b0;
      if (!ifc.rd_empty && ($urandom_range(0, 2) != 0)) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("rand_data", 64'(ifc.rd_data), 64'(e));
        ifc.rd_en = 1'b1;
      end
      if ((exp_q.size() < DEPTH) && ($urandom_range(0, 1) == 1)) begin
        d = IW'($urandom);
        s = ($urandom_range(0, 3) == 0);
        ifc.in_data = d;
        ifc.in_wen  = 1'b1;
        ifc.in_sof  = s;
        model_word(d, s);
      end
      tick();
    end
    ifc.rd_en  = 1'b0;
    ifc.in_wen = 1'b0;
    ifc.in_sof = 1'b0;
    for (int c = 0; (c < 40) && (exp_q.size() > 0); c++) begin
      if (!ifc.rd_empty) pop_val("rand_drain", exp_q.pop_front());
      else tick();
    end
    check("rand_all_seen", 64'(exp_q.size()), 64'd0);
    check("rand_empty", 64'(ifc.rd_empty), 64'd1);
    check("rand_fill0", 64'(ifc.fill_level), 64'd0);
    check("rand_no_ovf", 64'(ifc.overflow), 64'd0);
    check("rand_drop_kept", 64'(ifc.dropped_frames), 64'd1);

    // asynchronous reset mid-group
    send(16'h0F0F, 1'b1);
    send(16'hF0F0, 1'b0);
    tick();
    check("t7_fill1", 64'(ifc.fill_level), 64'd1);
    send(16'h1111, 1'b1);
    check("t7_in_pack", 64'(ifc.state), 64'(PACK));
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_arst_rd_data", 64'(ifc.rd_data), 64'd0);
    check("t7_arst_empty",   64'(ifc.rd_empty), 64'd1);
    check("t7_arst_ovf",     64'(ifc.overflow), 64'd0);
    check("t7_arst_fill",    64'(ifc.fill_level), 64'd0);
    check("t7_arst_dropped", 64'(ifc.dropped_frames), 64'd0);
    check("t7_arst_state",   64'(ifc.state), 64'(IDLE));
    tick();
    reset_n = 1'b1;
    tick();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
